// File: rtl/gshare_history_unit.sv
// gshare_history_unit
// Branch predictor front end around one saturating-counter table. The fetch PC
// is hashed with a speculative global history to index the table, predictions
// are returned one cycle later, and every accepted branch is remembered in an
// in-order queue. Resolutions retire the queue head, train the table and, on a
// wrong guess, rewind the speculative history to what it should have been.
module gshare_history_unit #(
    parameter int SIZE  = 4,
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_req,
    input  logic [PC_W-1:0]        pred_pc,
    output logic                   pred_ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    input  logic                   flush,
    output logic                   mispredict,
    input  logic [0:(2**SIZE)-1]   cnt_prediction,
    output logic                   cnt_modify,
    output logic                   cnt_is_increment,
    output logic [SIZE-1:0]        cnt_modify_idx
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    // History shift: oldest bit falls off the top, newest outcome enters bit 0.
    // Written as a truncating cast so it also holds for a one-bit history.
    function automatic logic [SIZE-1:0] shiftIn(input logic [SIZE-1:0] ghr, input logic dir);
        return SIZE'({ghr, dir});
    endfunction

    logic [SIZE-1:0] specGhr;
    logic [SIZE-1:0] archGhr;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [PW:0]     count;

    logic [SIZE-1:0] qIdx  [DEPTH];
    logic            qPred [DEPTH];
    logic [SIZE-1:0] qSnap [DEPTH];

    logic [SIZE-1:0] headIdx;
    logic            headPred;
    logic [SIZE-1:0] headSnap;

    logic [SIZE-1:0] predIdx;
    logic            predBit;
    logic            resolveAct;
    logic            squash;
    logic            accept;

    logic [SIZE-1:0] archGhrNext;
    logic [SIZE-1:0] specGhrNext;
    logic [PW:0]     countNext;
    logic [PW-1:0]   rdPtrNext;
    logic [PW-1:0]   wrPtrNext;

    // Upper PC bits do not take part in the hash.
    logic unusedPcBits;
    assign unusedPcBits = ^pred_pc;

    // Ready depends only on the registered occupancy, never on a same-cycle pop.
    assign pred_ready = (count < FULL_COUNT);

    assign headIdx  = qIdx[rdPtr];
    assign headPred = qPred[rdPtr];
    assign headSnap = qSnap[rdPtr];

    assign predIdx    = pred_pc[SIZE-1:0] ^ specGhr;
    assign predBit    = cnt_prediction[predIdx];
    assign resolveAct = resolve_valid & (count != '0);
    assign squash     = resolveAct & (resolve_taken != headPred);
    assign accept     = pred_req & pred_ready & ~flush & ~squash;

    // Next-state for histories, occupancy and pointers.
    always_comb begin
        archGhrNext = archGhr;
        specGhrNext = specGhr;
        countNext   = count;
        rdPtrNext   = rdPtr;
        wrPtrNext   = wrPtr;

        if (resolveAct) begin
            archGhrNext = shiftIn(archGhr, resolve_taken);
        end

        if (flush) begin
            // Flush wins over a mispredict: the architectural history already
            // includes any branch resolved this cycle, so it is the safe restart point.
            specGhrNext = archGhrNext;
            countNext   = '0;
            rdPtrNext   = wrPtr;
        end else if (squash) begin
            // Rewind to the history seen by the mispredicted branch, corrected.
            specGhrNext = shiftIn(headSnap, resolve_taken);
            countNext   = '0;
            rdPtrNext   = wrPtr;
        end else begin
            if (accept) begin
                specGhrNext = shiftIn(specGhr, predBit);
                wrPtrNext   = wrPtr + 1'b1;
            end
            if (resolveAct) begin
                rdPtrNext = rdPtr + 1'b1;
            end
            countNext = count + (PW + 1)'(accept) - (PW + 1)'(resolveAct);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            specGhr <= '0;
            archGhr <= '0;
            count   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
        end else begin
            specGhr <= specGhrNext;
            archGhr <= archGhrNext;
            count   <= countNext;
            rdPtr   <= rdPtrNext;
            wrPtr   <= wrPtrNext;
        end
    end

    // Queue payload storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            qIdx[wrPtr]  <= predIdx;
            qPred[wrPtr] <= predBit;
            qSnap[wrPtr] <= specGhr;
        end
    end

    // Registered outputs: prediction response, mispredict pulse and table training.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            mispredict       <= 1'b0;
            cnt_modify       <= 1'b0;
            cnt_is_increment <= 1'b0;
            cnt_modify_idx   <= '0;
        end else begin
            pred_valid       <= accept;
            pred_taken       <= accept & predBit;
            mispredict       <= squash;
            cnt_modify       <= resolveAct;
            cnt_is_increment <= resolveAct & resolve_taken;
            cnt_modify_idx   <= resolveAct ? headIdx : '0;
        end
    end

endmodule
